// File: rtl/njp_uio_arbiter.sv
// njp_uio_arbiter: round-robin owner of the tile's 8-bit uio pad bus for two requesters,
// with registered pad drive/sampling and a turnaround gap. Forced release: define NJP_ARB_TIMEOUT_EN.
module njp_uio_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req_i,
  input  logic [1:0] last_i,
  input  logic [1:0] dir_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [1:0] gnt_o,
  output logic [7:0] rdata_o,
  output logic [1:0] rvalid_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("HOLD_MAX must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_ptr;
  logic [TW-1:0]   r_turn_cnt;
  logic [1:0]      r_gnt;
  logic [7:0]      r_uio_out;
  logic [7:0]      r_uio_oe;
  logic [7:0]      r_rdata;
  logic [1:0]      r_rvalid;

  logic            w_winner;
  logic            w_own_req;
  logic            w_own_last;
  logic            w_own_dir;
  logic [7:0]      w_own_wdata;
  logic            w_forced;
  logic            w_exit;

  // Contention goes to the pointer; a lone requester wins outright.
  assign w_winner    = (req_i == 2'b11) ? r_ptr : req_i[1];
  assign w_own_req   = req_i[r_owner];
  assign w_own_last  = last_i[r_owner];
  assign w_own_dir   = dir_i[r_owner];
  assign w_own_wdata = r_owner ? wdata1_i : wdata0_i;

`ifdef NJP_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(HOLD_MAX + 1);
  logic [HCW-1:0] r_hold_cnt;
  logic           r_timeout;
  // Fires on the OWN cycle whose count is about to reach HOLD_MAX, so the grant lasts HOLD_MAX cycles.
  assign w_forced  = (r_hold_cnt == HCW'(HOLD_MAX - 1)) && w_own_req && !w_own_last;
  assign timeout_o = r_timeout;
`else
  assign w_forced  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign w_exit = w_own_last | ~w_own_req | w_forced;

  // NOTE: every state bit, ptr included, is cleared asynchronously; there is no storage array here
  // that could be left unreset. ena-low differs only in keeping ptr, so fairness survives a disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_ptr      <= 1'b0;
      r_turn_cnt <= '0;
      r_gnt      <= '0;
      r_uio_out  <= '0;
      r_uio_oe   <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
`ifdef NJP_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else if (!ena) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_turn_cnt <= '0;
      r_gnt      <= '0;
      r_uio_out  <= '0;
      r_uio_oe   <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
`ifdef NJP_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      r_rvalid <= '0;
`ifdef NJP_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_owner <= w_winner;
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            r_state <= S_OWN;
`ifdef NJP_ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        S_OWN: begin
          // The final beat is still registered to the pads and sampled.
          r_uio_out <= w_own_wdata;
          r_rdata   <= uio_in;
`ifdef NJP_ARB_TIMEOUT_EN
          if (r_hold_cnt != HCW'(HOLD_MAX)) r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
          if (w_exit) begin
            r_gnt      <= '0;
            r_uio_oe   <= '0;
            r_ptr      <= ~r_owner;
            r_turn_cnt <= '0;
            r_state    <= (TURN_CYC > 0) ? S_TURN : S_IDLE;
`ifdef NJP_ARB_TIMEOUT_EN
            r_timeout  <= w_forced;
`endif
          end else begin
            r_uio_oe          <= w_own_dir ? 8'hFF : 8'h00;
            r_rvalid[r_owner] <= ~w_own_dir;
          end
        end
        S_TURN: begin
          if (r_turn_cnt == TW'(TURN_CYC - 1)) r_state <= S_IDLE;
          else                                  r_turn_cnt <= r_turn_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uio_out  = r_uio_out;
  assign uio_oe   = r_uio_oe;
  assign gnt_o    = r_gnt;
  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_njp_uio_arbiter.sv
// Self-checking bench for njp_uio_arbiter: reset, write/read bursts via a data scoreboard,
// fairness, timeout (either build of NJP_ARB_TIMEOUT_EN) and ena/rst_n aborts.
module tb_njp_uio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] req_i;
  logic [1:0] last_i;
  logic [1:0] dir_i;
  logic [7:0] wdata0_i;
  logic [7:0] wdata1_i;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [1:0] gnt_o;
  logic [7:0] rdata_o;
  logic [1:0] rvalid_o;
  logic       busy_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  njp_uio_arbiter #(.HOLD_MAX(4), .TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_i(req_i), .last_i(last_i), .dir_i(dir_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .gnt_o(gnt_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 2'b00; last_i = 2'b00; dir_i = 2'b00;
    wdata0_i = 8'h00; wdata1_i = 8'h00; uio_in = 8'h00;
  endtask

  task automatic test_reset();
    ena = 1'b1;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    total++;
    if ({gnt_o, uio_oe, uio_out, rvalid_o, busy_o, timeout_o} !== 22'h0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b oe=%h out=%h rv=%b busy=%b to=%b want all 0",
               gnt_o, uio_oe, uio_out, rvalid_o, busy_o, timeout_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] data [4] = '{8'hA5, 8'h12, 8'h34, 8'h5E};
    logic [7:0] exp;
    req_i = 2'b01; dir_i = 2'b01; wdata0_i = 8'hA5;
    tick();
    total++;
    if ({gnt_o, uio_oe, busy_o} !== {2'b01, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL write_grant: got gnt=%b oe=%h busy=%b want gnt=01 oe=00 busy=1", gnt_o, uio_oe, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      wdata0_i = data[i];
      last_i   = (i == 3) ? 2'b01 : 2'b00;
      sb_q.push_back(data[i]);
      tick();
      exp = sb_q.pop_front();
      total++;
      if (uio_out !== exp) begin
        bad++;
        $display("FAIL write_data%0d: got %h want %h", i, uio_out, exp);
      end
      total++;
      if (i < 3 && {gnt_o, uio_oe} !== {2'b01, 8'hFF}) begin
        bad++;
        $display("FAIL write_own%0d: got gnt=%b oe=%h want gnt=01 oe=FF", i, gnt_o, uio_oe);
      end else if (i == 3 && {gnt_o, uio_oe, busy_o} !== {2'b00, 8'h00, 1'b1}) begin
        bad++;
        $display("FAIL write_release: got gnt=%b oe=%h busy=%b want gnt=00 oe=00 busy=1", gnt_o, uio_oe, busy_o);
      end
    end
    req_i = 2'b00; last_i = 2'b00;
    tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL write_busy_end: got %b want 0", busy_o);
    end
  endtask

  task automatic test_fairness();
    test_reset();
    req_i = 2'b11; dir_i = 2'b00;
    tick();
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL fair_first: got %b want 01", gnt_o); end
    last_i = 2'b01;
    tick();
    last_i = 2'b00;
    total++;
    if ({gnt_o, uio_oe} !== 10'h0) begin bad++; $display("FAIL fair_drop0: got gnt=%b oe=%h want 0", gnt_o, uio_oe); end
    tick();
    total++;
    if ({gnt_o, busy_o} !== 3'b000) begin bad++; $display("FAIL fair_turn: got gnt=%b busy=%b want 00 0", gnt_o, busy_o); end
    tick();
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL fair_second: got %b want 10", gnt_o); end
    last_i = 2'b10;
    tick();
    last_i = 2'b00;
    tick();
    tick();
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL fair_third: got %b want 01", gnt_o); end
    req_i = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_read();
    logic [7:0] vals [3] = '{8'h3C, 8'hC3, 8'h5A};
    logic [7:0] exp;
    req_i = 2'b10; dir_i = 2'b00; uio_in = 8'h3C;
    tick();
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL read_grant: got %b want 10", gnt_o); end
    for (int i = 0; i < 3; i++) begin
      uio_in = vals[i];
      sb_q.push_back(vals[i]);
      tick();
      total++;
      if ({rvalid_o, uio_oe} !== {2'b10, 8'h00}) begin
        bad++;
        $display("FAIL read_valid%0d: got rv=%b oe=%h want rv=10 oe=00", i, rvalid_o, uio_oe);
      end
      if (rvalid_o == 2'b10 && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        total++;
        if (rdata_o !== exp) begin bad++; $display("FAIL read_data%0d: got %h want %h", i, rdata_o, exp); end
      end
    end
    sb_q.delete();
    uio_in = 8'h99; last_i = 2'b10;
    tick();
    total++;
    if ({gnt_o, rvalid_o, rdata_o} !== {2'b00, 2'b00, 8'h99}) begin
      bad++;
      $display("FAIL read_last: got gnt=%b rv=%b rdata=%h want 00 00 99", gnt_o, rvalid_o, rdata_o);
    end
    req_i = 2'b00; last_i = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    test_reset();
    req_i = 2'b01; dir_i = 2'b01;
    tick();
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_grant: got %b want 01", gnt_o); end
`ifdef NJP_ARB_TIMEOUT_EN
    req_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({gnt_o, timeout_o} !== 3'b010) begin
        bad++;
        $display("FAIL to_hold%0d: got gnt=%b to=%b want 01 0", i, gnt_o, timeout_o);
      end
    end
    tick();
    total++;
    if ({gnt_o, timeout_o, uio_oe} !== {2'b00, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL to_release: got gnt=%b to=%b oe=%h want 00 1 00", gnt_o, timeout_o, uio_oe);
    end
    tick();
    total++;
    if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b want 0", timeout_o); end
    tick();
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL to_next: got %b want 10", gnt_o); end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if ({gnt_o, timeout_o} !== 3'b010) begin
        bad++;
        $display("FAIL nto_hold%0d: got gnt=%b to=%b want 01 0", i, gnt_o, timeout_o);
      end
    end
`endif
    req_i = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_abort();
    test_reset();
    req_i = 2'b01; dir_i = 2'b11; wdata0_i = 8'h5A; wdata1_i = 8'hC7;
    tick();
    last_i = 2'b01;
    tick();
    last_i = 2'b00; req_i = 2'b00;
    tick();
    req_i = 2'b01;
    tick();
    tick();
    total++;
    if ({uio_oe, uio_out} !== 16'hFF5A) begin bad++; $display("FAIL abort_pre: got oe=%h out=%h want FF 5A", uio_oe, uio_out); end
    ena = 1'b0;
    tick();
    total++;
    if ({gnt_o, uio_oe, uio_out, rvalid_o, rdata_o, busy_o, timeout_o} !== 30'h0) begin
      bad++;
      $display("FAIL abort_ena: got gnt=%b oe=%h out=%h rv=%b busy=%b want all 0", gnt_o, uio_oe, uio_out, rvalid_o, busy_o);
    end
    ena = 1'b1; req_i = 2'b11;
    tick();
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL abort_ptr_kept: got %b want 10", gnt_o); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt_o, uio_oe, uio_out, rvalid_o, busy_o} !== 21'h0) begin
      bad++;
      $display("FAIL abort_rst: got gnt=%b oe=%h out=%h busy=%b want all 0", gnt_o, uio_oe, uio_out, busy_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL abort_ptr_reset: got %b want 01", gnt_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_fairness();
    test_read();
    test_timeout();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
